// File: rtl/id_issue_ctrl.sv
// Decode-stage issue control: register scoreboard, FPU occupancy, branch flush.
// Optional stall statistics counter enabled with `define ID_ISSUE_STATS_EN.
module id_issue_ctrl #(
  parameter int REGFILE_LEN = 6,
  parameter int FPU_LATENCY = 4,
  parameter int STAT_WIDTH  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        id_valid,
  input  logic [REGFILE_LEN-1:0]      rs1,
  input  logic [REGFILE_LEN-1:0]      rs2,
  input  logic [REGFILE_LEN-1:0]      rd,
  input  logic                        use_rs1,
  input  logic                        use_rs2,
  input  logic                        reg_write,
  input  logic                        alu_fpu,
  input  logic                        imm_pc,
  input  logic                        ex_ready,
  input  logic                        wb_reg_write,
  input  logic [REGFILE_LEN-1:0]      wb_rd,
  output logic                        id_issue,
  output logic                        id_stall,
  output logic                        if_flush,
  output logic                        fpu_busy,
`ifdef ID_ISSUE_STATS_EN
  output logic [STAT_WIDTH-1:0]       stall_cycles,
`endif
  output logic [2**REGFILE_LEN-1:0]   busy_vec
);

  localparam int NREG = 2**REGFILE_LEN;
  localparam int CW   = $clog2(FPU_LATENCY + 1);

  logic [NREG-1:0] busy_q, busy_d;
  logic [CW-1:0]   fcnt_q, fcnt_d;
  logic            flush_q;
  logic            hazard;

  assign fpu_busy = (fcnt_q != '0);
  assign if_flush = flush_q;
  assign busy_vec = busy_q;

  always_comb begin
    hazard = 1'b0;
    if (use_rs1 && busy_q[rs1])   hazard = 1'b1;
    if (use_rs2 && busy_q[rs2])   hazard = 1'b1;
    if (reg_write && busy_q[rd])  hazard = 1'b1;
    if (alu_fpu && fpu_busy)      hazard = 1'b1;
  end

  // A flushed slot is a wrong-path bubble: neither issued nor stalled.
  assign id_issue = id_valid & ~hazard & ex_ready & ~flush_q;
  assign id_stall = id_valid & ~id_issue & ~flush_q;

  // Clear first so that a same-index set in this cycle wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_reg_write && (wb_rd != '0))
      busy_d[wb_rd] = 1'b0;
    if (id_issue && reg_write && (rd != '0))
      busy_d[rd] = 1'b1;
  end

  always_comb begin
    fcnt_d = fcnt_q;
    if (id_issue && alu_fpu)
      fcnt_d = CW'(FPU_LATENCY);
    else if (fpu_busy)
      fcnt_d = fcnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      fcnt_q  <= '0;
      flush_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      fcnt_q  <= fcnt_d;
      flush_q <= id_issue & imm_pc;
    end
  end

`ifdef ID_ISSUE_STATS_EN
  logic [STAT_WIDTH-1:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= '0;
    else if (id_stall && (stall_q != '1))
      stall_q <= stall_q + STAT_WIDTH'(1);
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: doc/id_issue_ctrl.md
Name: id_issue_ctrl

Overview:
- Issue controller for the decode stage; sits between decode and execute.
- Keeps a scoreboard of pending register writes across the unified int/fp register index space (bit 5 selects fp).
- Stalls decode on RAW/WAW hazards and on a busy multi-cycle FPU, and flushes fetch when a branch or jump resolved in decode issues.

Parameters:
- REGFILE_LEN, 6, register index width; scoreboard holds 2**REGFILE_LEN busy bits.
- FPU_LATENCY, 4, cycles the FPU is occupied after an FPU op issues (min 1).
- STAT_WIDTH, 32, width of the stall counter (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode holds a valid instruction.
- rs1  in  REGFILE_LEN  source 1 index.
- rs2  in  REGFILE_LEN  source 2 index.
- rd  in  REGFILE_LEN  destination index.
- use_rs1  in  1  instruction reads rs1.
- use_rs2  in  1  instruction reads rs2.
- reg_write  in  1  instruction writes rd.
- alu_fpu  in  1  instruction uses the FPU.
- imm_pc  in  1  branch taken or jump, resolved in decode.
- ex_ready  in  1  execute stage can accept.
- wb_reg_write  in  1  writeback write enable.
- wb_rd  in  REGFILE_LEN  writeback index.
- id_issue  out  1  instruction leaves decode this cycle.
- id_stall  out  1  hold PC and IF/ID register.
- if_flush  out  1  squash the IF/ID register (registered, one cycle).
- fpu_busy  out  1  FPU occupancy counter is nonzero.
- busy_vec  out  2**REGFILE_LEN  scoreboard state.

Behaviour:
- Reset, asynchronous on rst_n low: busy_vec = 0, FPU counter = 0, if_flush = 0, stall counter = 0. id_issue and id_stall are combinational and read 0 while id_valid = 0.
- Index 0 (integer x0) is never marked busy and never causes a hazard. Fp index 32 is a real register and is tracked.
- hazard is asserted when any of these holds:
  - use_rs1 and busy[rs1];
  - use_rs2 and busy[rs2];
  - reg_write and busy[rd] (WAW);
  - alu_fpu and fpu_busy.
- id_issue = id_valid & ~hazard & ex_ready & ~if_flush.
- id_stall = id_valid & ~id_issue & ~if_flush.
- Scoreboard update, per rising edge:
  - on id_issue & reg_write & rd≠0, set busy[rd];
  - on wb_reg_write & wb_rd≠0, clear busy[wb_rd];
  - same index set and cleared in the same cycle: set wins.
- A WB clear becomes visible the cycle after. No same-cycle bypass: the regfile write lands on the edge, so decode stalls one extra cycle.
- FPU counter:
  - on id_issue & alu_fpu, load FPU_LATENCY;
  - otherwise decrement when nonzero (saturating at 0);
  - fpu_busy = (counter≠0).
- Flush: if_flush <= id_issue & imm_pc. While if_flush = 1, decode's contents are a wrong-path bubble: no issue, no stall, no scoreboard set.
- Branch operands are checked through use_rs1/use_rs2 like any other source. A branch never issues on stale comparator data.
- Reset mid-operation clears all pending state. Writebacks arriving afterwards are harmless because clears of already-clear bits are no-ops.

Optional Feature:
- Macro ID_ISSUE_STATS_EN.
- When defined: extra output stall_cycles (STAT_WIDTH) counts cycles with id_stall = 1. It saturates at all-ones and is reset to 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- RAW: issue rd=5 reg_write, then rs1=5 use_rs1 → id_stall=1 until the cycle after wb_reg_write with wb_rd=5; issue on that following cycle.
- x0 and set-wins: issue rd=0 → busy_vec stays 0. Same-cycle issue rd=7 with WB of 7 → busy[7]=1 afterwards.
- FPU structural, FPU_LATENCY=4: FPU op issues at cycle t → second FPU op stalls at t+1..t+4 and issues at t+5. A non-FPU op at t+1 with no hazard issues.
- Branch flush: id_valid, imm_pc=1, no hazard, ex_ready=1 → id_issue=1, then if_flush=1 for exactly one cycle with id_issue=0 and id_stall=0.
- Backpressure/WAW: ex_ready=0 → id_stall=1, busy unchanged. Instruction with rd=33 while busy[33] → stall until cleared.
- Async reset: assert rst_n=0 mid-stall with busy[9]=1 and FPU counter=3 → busy_vec=0, fpu_busy=0, if_flush=0 immediately without a clock edge. Stall counter=0 when ID_ISSUE_STATS_EN is defined.
